inst_fetch_ctrl: RTL

Fetch controller that sequences the byte-addressed, combinational-read instruction memory. It owns the fetch PC and drives the memory address each cycle. Each returned 32-bit word is captured, tagged with its PC, and buffered in a small queue. Decode drains the queue over a valid/ready handshake; branch/jump redirects flush the queue and restart fetch.

---
 rtl/inst_fetch_pkg.sv | 10 +
 rtl/inst_fetch_ctrl_queue.sv | 41 ++++
 rtl/inst_fetch_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the instruction fetch controller
package inst_fetch_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic {RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_ctrl_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush and a head read port
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  entry_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  // storage, pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= entry_i;
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the fetch PC, tags fetched words and buffers them for decode
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 4,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic        halted
);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0]   fpc_q, fpc_d;
  fetch_state_e  state_q, state_d;
  logic [CW-1:0] count;
  fetch_entry_t  head, entry;
  logic          push, pop, legal;
  // fetch PC and run/halt state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      state_q <= RUN;
    end else begin
      fpc_q   <= fpc_d;
      state_q <= state_d;
    end
  end
  // handshake gating, entry formation and next state; redirect overrides everything
  always_comb begin
    legal     = fpc_q[1:0] == 2'b00 && fpc_q <= 32'(MEM_BYTES - 4);
    out_valid = count != '0 && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = state_q == RUN && fetch_en && !redirect_valid && (count < CW'(QDEPTH) || pop);
    entry     = legal ? {imem_inst, fpc_q, 1'b0} : {NOP_INST, fpc_q, 1'b1};
    fpc_d     = redirect_valid ? redirect_pc : (push && legal) ? fpc_q + 32'd4 : fpc_q;
    state_d   = redirect_valid ? RUN : (push && !legal) ? HALT : state_q;
  end
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i (entry),
    .count_o (count),
    .head_o  (head)
  );
  assign imem_pc   = fpc_q;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_fault = head.fault;
  assign halted    = state_q == HALT;
endmodule
